// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader: FSM encoding,
// word/byte geometry and counter widths.
package loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_GAP,
        ST_START
    } state_e;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
    localparam int CNT_W          = 5;

    // The GAP counter has to hold values up to GAP.
    function automatic int gap_cnt_w(input int gap);
        return $clog2(gap + 1);
    endfunction

endpackage

// File: rtl/loader_fifo.sv
// Synchronous show-ahead FIFO; a push and a pop in the same cycle are legal
// even when full, because the pop frees the slot the push writes into.
module loader_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Program-load stage: assembles big-endian words from a byte stream, buffers
// them, and replays them to the cpu as spaced mem_write pulses plus a start.
module instr_loader
    import loader_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int GAP       = 3,
    parameter int MAX_INSTR = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              go,
    output logic [WORD_W-1:0] next_instruction,
    output logic              mem_write,
    output logic              start,
    output logic [CNT_W-1:0]  loaded_count,
    output logic              busy,
    output logic              overflow
);

    localparam int                    GAP_W    = gap_cnt_w(GAP);
    localparam logic [GAP_W-1:0]      GAP_LAST = GAP_W'(GAP - 1);
    localparam logic [CNT_W-1:0]      MAX_CNT  = CNT_W'(MAX_INSTR);
    localparam logic [BYTE_CNT_W-1:0] BC_LAST  = BYTE_CNT_W'(BYTES_PER_WORD - 1);
    localparam int                    PART_W   = WORD_W - BYTE_W;

    // Assembler and handshake state
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [PART_W-1:0]     partial_q, partial_d;
    logic                  start_pending_q, start_pending_d;
    logic                  ready_en_q;
    logic                  byte_accept;

    // FIFO interface
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [WORD_W-1:0]     fifo_din;
    logic [WORD_W-1:0]     fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;

    // FSM state and registered outputs
    state_e                state_q;
    logic [GAP_W-1:0]      gap_cnt_q;
    logic [WORD_W-1:0]     next_instr_q;
    logic                  mem_write_q;
    logic                  start_q;
    logic [CNT_W-1:0]      loaded_count_q;
    logic                  overflow_q;

    // ready_en_q keeps byte_ready low until the first edge after reset release.
    assign byte_ready  = ready_en_q && !fifo_full && !start_pending_q;
    assign byte_accept = byte_valid && byte_ready;
    assign fifo_pop    = (state_q == ST_IDLE) && !fifo_empty;

    always_comb begin
        byte_cnt_d      = byte_cnt_q;
        partial_d       = partial_q;
        fifo_push       = 1'b0;
        fifo_din        = {partial_q, byte_in};
        start_pending_d = (state_q == ST_START) ? 1'b0 : (start_pending_q || go);

        if (start_pending_q) begin
            // A pending start abandons any half-assembled word.
            byte_cnt_d = '0;
        end else if (byte_accept) begin
            if (byte_cnt_q == BC_LAST) begin
                fifo_push  = 1'b1;
                byte_cnt_d = '0;
            end else begin
                partial_d  = {partial_q[PART_W-BYTE_W-1:0], byte_in};
                byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt_q      <= '0;
            partial_q       <= '0;
            start_pending_q <= 1'b0;
            ready_en_q      <= 1'b0;
        end else begin
            byte_cnt_q      <= byte_cnt_d;
            partial_q       <= partial_d;
            start_pending_q <= start_pending_d;
            ready_en_q      <= 1'b1;
        end
    end

    loader_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            gap_cnt_q      <= '0;
            next_instr_q   <= '0;
            mem_write_q    <= 1'b0;
            start_q        <= 1'b0;
            loaded_count_q <= '0;
            overflow_q     <= 1'b0;
        end else begin
            mem_write_q <= 1'b0;
            start_q     <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_pending_q && fifo_empty) begin
                        start_q <= 1'b1;
                        state_q <= ST_START;
                    end else if (!fifo_empty) begin
                        if (loaded_count_q < MAX_CNT) begin
                            next_instr_q <= fifo_dout;
                            mem_write_q  <= 1'b1;
                            state_q      <= ST_WRITE;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    loaded_count_q <= loaded_count_q + CNT_W'(1);
                    gap_cnt_q      <= '0;
                    state_q        <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                ST_START: begin
                    loaded_count_q <= '0;
                    overflow_q     <= 1'b0;
                    state_q        <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign next_instruction = next_instr_q;
    assign mem_write        = mem_write_q;
    assign start            = start_q;
    assign loaded_count     = loaded_count_q;
    assign overflow         = overflow_q;
    assign busy             = !fifo_empty || (state_q != ST_IDLE) || start_pending_q;

endmodule
